pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_if.sv | 24 ++
 rtl/pipeline_ctrl.sv | 56 +++++
 tb/tb_pipeline_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: stall/exception request bundle between the pipeline and its control unit
interface pipeline_ctrl_if;
  logic stallreq_if;
  logic stallreq_id;
  logic stallreq_ex;
  logic stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic perf_clr;
  logic [5:0] stall;
  logic flush;
  logic [31:0] new_pc;
  logic wdog_err;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i, perf_clr,
    input stall, flush, new_pc, wdog_err, stall_cycles, flush_count
  );
  modport slave (
    input stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i, perf_clr,
    output stall, flush, new_pc, wdog_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall arbitration, MEM-stage exception flush/redirect, stall watchdog and perf counters
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input logic clk,
  input logic rst,
  pipeline_ctrl_if.slave bus
);
  typedef enum logic {RUN, GAP} state_t;
  localparam logic [31:0] ERET = 32'h0000_000e;
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_LIMIT - 1);
  state_t state_q, state_d;
  logic [15:0] run_q, run_d;
  logic [31:0] sc_q, sc_d;
  logic [15:0] fc_q, fc_d;
  logic wdog_q, wdog_d;
  logic exc, stalled;
  logic [5:0] req_stall, stall_c;
  logic [31:0] pc_c;
  // The GAP cycle masks everything: MEM holds a flushed bubble and any request is stale
  always_comb begin
    exc = !rst && state_q == RUN && |bus.excepttype_i;
    req_stall = bus.stallreq_mem ? 6'b011111 : bus.stallreq_ex ? 6'b001111 :
                bus.stallreq_id ? 6'b000111 : bus.stallreq_if ? 6'b000011 : 6'b000000;
    stall_c = (rst || state_q == GAP || exc) ? 6'b000000 : req_stall;
    stalled = |stall_c;
    pc_c = !exc ? 32'd0 : bus.excepttype_i == ERET ? bus.cp0_epc_i : EXC_VECTOR;
    state_d = exc ? GAP : RUN;
    run_d = !stalled ? 16'd0 : &run_q ? run_q : run_q + 16'd1;
    wdog_d = wdog_q | (stalled && run_q == WDOG_LAST);
    sc_d = bus.perf_clr ? 32'd0 : (stalled && !(&sc_q)) ? sc_q + 32'd1 : sc_q;
    fc_d = bus.perf_clr ? 16'd0 : (exc && !(&fc_q)) ? fc_q + 16'd1 : fc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      run_q <= '0;
      sc_q <= '0;
      fc_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      sc_q <= sc_d;
      fc_q <= fc_d;
      wdog_q <= wdog_d;
    end
  end
  assign bus.stall = stall_c;
  assign bus.flush = exc;
  assign bus.new_pc = pc_c;
  assign bus.wdog_err = wdog_q;
  assign bus.stall_cycles = sc_q;
  assign bus.flush_count = fc_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized traffic checked against a cycle-level reference model
module tb_pipeline_ctrl;
  localparam int LIMIT = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  bit m_gap, m_wdog;
  int m_run, m_fc;
  longint m_sc;
  pipeline_ctrl_if bus();
  pipeline_ctrl #(.EXC_VECTOR(32'h0000_0020), .WDOG_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic m_flush();
    return !rst && !m_gap && bus.excepttype_i != 0;
  endfunction
  function automatic logic [5:0] m_stall();
    int n;
    if (rst || m_gap || bus.excepttype_i != 0) return 6'd0;
    n = bus.stallreq_mem ? 5 : bus.stallreq_ex ? 4 : bus.stallreq_id ? 3 : bus.stallreq_if ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction
  function automatic logic [31:0] m_pc();
    if (!m_flush()) return 32'd0;
    return bus.excepttype_i == 32'h0000_000e ? bus.cp0_epc_i : 32'h0000_0020;
  endfunction
  task automatic drive(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc, input logic clr);
    {bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if} = req;
    bus.excepttype_i = exc;
    bus.cp0_epc_i = epc;
    bus.perf_clr = clr;
    #1;
  endtask
  task automatic tick();
    logic [5:0] s;
    logic f;
    s = m_stall();
    f = m_flush();
    @(posedge clk);
    if (rst) begin
      m_gap = 0; m_run = 0; m_wdog = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (s != 0 && m_run == LIMIT - 1) m_wdog = 1;
      m_run = s != 0 ? m_run + 1 : 0;
      m_sc = bus.perf_clr ? 0 : (s != 0 && m_sc < 64'hFFFF_FFFF) ? m_sc + 1 : m_sc;
      m_fc = bus.perf_clr ? 0 : (f && m_fc < 65535) ? m_fc + 1 : m_fc;
      m_gap = f;
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1;
    drive(4'b1111, 32'h8, 32'h1234, 1'b0);
    total++; if (bus.stall !== 6'd0) $display("FAIL reset_stall got %b want %b", bus.stall, 6'd0); else passed++;
    total++; if (bus.flush !== 1'b0) $display("FAIL reset_flush got %b want 0", bus.flush); else passed++;
    total++; if (bus.new_pc !== 32'd0) $display("FAIL reset_new_pc got %h want 0", bus.new_pc); else passed++;
    tick(); tick();
    total++; if (bus.wdog_err !== 1'b0) $display("FAIL reset_wdog got %b want 0", bus.wdog_err); else passed++;
    total++; if (bus.stall_cycles !== 32'd0) $display("FAIL reset_sc got %0d want 0", bus.stall_cycles); else passed++;
    total++; if (bus.flush_count !== 16'd0) $display("FAIL reset_fc got %0d want 0", bus.flush_count); else passed++;
    rst = 0;
  endtask
  task automatic test_priority();
    drive(4'b0110, 32'h0, 32'h0, 1'b0);
    total++; if (bus.stall !== 6'b001111) $display("FAIL prio_ex_id got %b want 001111", bus.stall); else passed++;
    total++; if (bus.flush !== 1'b0) $display("FAIL prio_flush got %b want 0", bus.flush); else passed++;
    tick();
    drive(4'b0001, 32'h0, 32'h0, 1'b0);
    total++; if (bus.stall !== 6'b000011) $display("FAIL prio_if got %b want 000011", bus.stall); else passed++;
    tick();
    drive(4'b1111, 32'h0, 32'h0, 1'b0);
    total++; if (bus.stall !== 6'b011111) $display("FAIL prio_mem got %b want 011111", bus.stall); else passed++;
    tick();
  endtask
  task automatic test_exception();
    drive(4'b1000, 32'h8, 32'h0, 1'b0);
    total++; if (bus.flush !== 1'b1) $display("FAIL exc_flush got %b want 1", bus.flush); else passed++;
    total++; if (bus.stall !== 6'd0) $display("FAIL exc_stall got %b want 0", bus.stall); else passed++;
    total++; if (bus.new_pc !== 32'h20) $display("FAIL exc_new_pc got %h want 00000020", bus.new_pc); else passed++;
    tick();
    drive(4'b1000, 32'hc, 32'h0, 1'b0);
    total++; if (bus.flush !== 1'b0) $display("FAIL gap_flush got %b want 0", bus.flush); else passed++;
    total++; if (bus.new_pc !== 32'd0) $display("FAIL gap_new_pc got %h want 0", bus.new_pc); else passed++;
    total++; if (bus.stall !== 6'd0) $display("FAIL gap_stall got %b want 0", bus.stall); else passed++;
    tick();
    total++; if (bus.flush !== 1'b1) $display("FAIL exc2_flush got %b want 1", bus.flush); else passed++;
    tick();
    drive(4'b0000, 32'h0, 32'h0, 1'b0);
    tick();
  endtask
  task automatic test_eret();
    drive(4'b0100, 32'he, 32'hBFC0_0100, 1'b0);
    total++; if (bus.new_pc !== 32'hBFC0_0100) $display("FAIL eret_new_pc got %h want bfc00100", bus.new_pc); else passed++;
    total++; if (bus.flush !== 1'b1) $display("FAIL eret_flush got %b want 1", bus.flush); else passed++;
    tick();
    drive(4'b0000, 32'h0, 32'h0, 1'b0);
    tick();
  endtask
  task automatic test_watchdog();
    rst = 1; tick(); rst = 0;
    drive(4'b0100, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i <= 8; i++) begin
      total++; if (bus.wdog_err !== (i == 8)) $display("FAIL wdog_after_%0d got %b want %b", i, bus.wdog_err, i == 8); else passed++;
      total++; if (bus.stall_cycles !== 32'(i)) $display("FAIL wdog_sc_%0d got %0d want %0d", i, bus.stall_cycles, i); else passed++;
      if (i < 8) tick();
    end
    drive(4'b0000, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    total++; if (bus.wdog_err !== 1'b1) $display("FAIL wdog_sticky got %b want 1", bus.wdog_err); else passed++;
    total++; if (bus.stall_cycles !== 32'd8) $display("FAIL wdog_sc_hold got %0d want 8", bus.stall_cycles); else passed++;
    rst = 1; tick(); rst = 0;
    total++; if (bus.wdog_err !== 1'b0) $display("FAIL wdog_rst got %b want 0", bus.wdog_err); else passed++;
  endtask
  task automatic test_saturation();
    force dut.fc_q = 16'hFFFE;
    #1 release dut.fc_q;
    m_fc = 65534;
    drive(4'b0000, 32'h8, 32'h0, 1'b0);
    total++; if (bus.flush_count !== 16'hFFFE) $display("FAIL sat_preload got %h want fffe", bus.flush_count); else passed++;
    tick();
    total++; if (bus.flush_count !== 16'hFFFF) $display("FAIL sat_first got %h want ffff", bus.flush_count); else passed++;
    tick();
    tick();
    total++; if (bus.flush_count !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", bus.flush_count); else passed++;
    drive(4'b1000, 32'h0, 32'h0, 1'b0);
    tick();
    drive(4'b1000, 32'h0, 32'h0, 1'b1);
    tick();
    total++; if (bus.stall_cycles !== 32'd0) $display("FAIL clr_sc got %0d want 0", bus.stall_cycles); else passed++;
    total++; if (bus.flush_count !== 16'd0) $display("FAIL clr_fc got %0d want 0", bus.flush_count); else passed++;
    drive(4'b1000, 32'h0, 32'h0, 1'b0);
    tick();
    total++; if (bus.stall_cycles !== 32'd1) $display("FAIL clr_resume got %0d want 1", bus.stall_cycles); else passed++;
  endtask
  task automatic test_reset_mid();
    drive(4'b0000, 32'h8, 32'h0, 1'b0);
    tick();
    rst = 1;
    drive(4'b1000, 32'h0, 32'h0, 1'b0);
    total++; if (bus.stall !== 6'd0) $display("FAIL rmid_stall got %b want 0", bus.stall); else passed++;
    total++; if (bus.flush !== 1'b0) $display("FAIL rmid_flush got %b want 0", bus.flush); else passed++;
    tick();
    total++; if (bus.stall_cycles !== 32'd0) $display("FAIL rmid_sc got %0d want 0", bus.stall_cycles); else passed++;
    total++; if (bus.flush_count !== 16'd0) $display("FAIL rmid_fc got %0d want 0", bus.flush_count); else passed++;
    rst = 0;
    #1;
    total++; if (bus.stall !== 6'b011111) $display("FAIL rmid_release got %b want 011111", bus.stall); else passed++;
    tick();
  endtask
  task automatic test_random();
    logic [31:0] exc;
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom % 60) == 0;
      exc = ($urandom % 6) != 0 ? 32'd0 : ($urandom % 3) == 0 ? 32'he : 32'($urandom_range(1, 31));
      drive(4'($urandom), exc, $urandom, ($urandom % 40) == 0);
      total++; if (bus.stall !== m_stall()) $display("FAIL rnd_stall_%0d got %b want %b", i, bus.stall, m_stall()); else passed++;
      total++; if (bus.flush !== m_flush()) $display("FAIL rnd_flush_%0d got %b want %b", i, bus.flush, m_flush()); else passed++;
      total++; if (bus.new_pc !== m_pc()) $display("FAIL rnd_new_pc_%0d got %h want %h", i, bus.new_pc, m_pc()); else passed++;
      total++; if (bus.wdog_err !== m_wdog) $display("FAIL rnd_wdog_%0d got %b want %b", i, bus.wdog_err, m_wdog); else passed++;
      total++; if (bus.stall_cycles !== 32'(m_sc)) $display("FAIL rnd_sc_%0d got %0d want %0d", i, bus.stall_cycles, m_sc); else passed++;
      total++; if (bus.flush_count !== 16'(m_fc)) $display("FAIL rnd_fc_%0d got %0d want %0d", i, bus.flush_count, m_fc); else passed++;
      tick();
    end
    rst = 0;
  endtask
  initial begin
    drive(4'b0000, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    test_reset();
    test_priority();
    test_exception();
    test_eret();
    test_watchdog();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
